// File: rtl/idle_monitor_pkg.sv
// Shared types and parameter limits for the per-peripheral idle monitor.
package idle_monitor_pkg;

    typedef enum logic [1:0] {
        CH_OFF,
        CH_ACTIVE,
        CH_IDLE
    } ch_state_t;

    localparam int unsigned N_MIN     = 1;
    localparam int unsigned N_MAX     = 32;
    localparam int unsigned W_MIN     = 2;
    localparam int unsigned W_MAX     = 32;
    localparam int unsigned WIN_W_MIN = 1;
    localparam int unsigned WIN_W_MAX = 32;

endpackage

// File: rtl/idle_monitor_if.sv
// Bundle between the activity sources / cfg_regs and the idle monitor.
interface idle_monitor_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 16,
    parameter int unsigned WIN_W = 8
);

    logic [N-1:0]     activity_pulse;
    logic [N-1:0]     periph_en;
    logic [W-1:0]     idle_thresh;
    logic [WIN_W-1:0] win_len;
    logic [N-1:0]     sat_clr;
    logic [N*W-1:0]   idle_count;
    logic [N-1:0]     recent_activity;
    logic [N-1:0]     idle;
    logic [N-1:0]     idle_irq;
    logic [N-1:0]     wake_irq;
    logic [N-1:0]     sat;

    modport master (
        output activity_pulse, periph_en, idle_thresh, win_len, sat_clr,
        input  idle_count, recent_activity, idle, idle_irq, wake_irq, sat
    );

    modport slave (
        input  activity_pulse, periph_en, idle_thresh, win_len, sat_clr,
        output idle_count, recent_activity, idle, idle_irq, wake_irq, sat
    );

endinterface

// File: rtl/idle_monitor_ch.sv
// One monitored channel: OFF/ACTIVE/IDLE FSM, saturating idle counter,
// recent-activity window timer, irq pulses and sticky saturation flag.
module idle_monitor_ch
    import idle_monitor_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned WIN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_pulse,
    input  logic [W-1:0]     i_thresh,
    input  logic [WIN_W-1:0] i_win_len,
    input  logic             i_sat_clr,
    output logic [W-1:0]     o_count,
    output logic             o_recent,
    output logic             o_idle,
    output logic             o_idle_irq,
    output logic             o_wake_irq,
    output logic             o_sat
);

    localparam logic [W-1:0] CNT_MAX = '1;

    ch_state_t        r_state;
    ch_state_t        w_state_nxt;
    logic [W-1:0]     r_cnt;
    logic [W-1:0]     w_cnt_nxt;
    logic [WIN_W-1:0] r_tmr;
    logic [WIN_W-1:0] w_tmr_nxt;
    logic             r_sat;
    logic             w_sat_nxt;
    logic             r_recent;
    logic             r_idle;
    logic             r_idle_irq;
    logic             r_wake_irq;
    logic             w_idle_irq;
    logic             w_wake_irq;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tmr_nxt   = r_tmr;
        w_sat_nxt   = r_sat;
        w_idle_irq  = 1'b0;
        w_wake_irq  = 1'b0;

        if (!i_en) begin
            w_state_nxt = CH_OFF;
            w_cnt_nxt   = '0;
            w_tmr_nxt   = '0;
            w_sat_nxt   = 1'b0;
        end else begin
            if (i_pulse) begin
                w_cnt_nxt = '0;
            end else if (r_cnt != CNT_MAX) begin
                w_cnt_nxt = r_cnt + W'(1);
            end

            if (i_pulse) begin
                w_tmr_nxt = i_win_len;
            end else if (r_tmr != '0) begin
                w_tmr_nxt = r_tmr - WIN_W'(1);
            end

            // Only the transition into all-ones sets sat, so a clear while
            // the counter is parked at all-ones sticks.
            if (r_cnt != CNT_MAX && w_cnt_nxt == CNT_MAX) begin
                w_sat_nxt = 1'b1;
            end else if (i_sat_clr) begin
                w_sat_nxt = 1'b0;
            end

            case (r_state)
                CH_OFF: begin
                    w_state_nxt = CH_ACTIVE;
                end
                CH_ACTIVE: begin
                    if (i_thresh != '0 && !i_pulse && w_cnt_nxt >= i_thresh) begin
                        w_state_nxt = CH_IDLE;
                        w_idle_irq  = 1'b1;
                    end
                end
                CH_IDLE: begin
                    if (i_pulse) begin
                        w_state_nxt = CH_ACTIVE;
                        w_wake_irq  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = CH_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= CH_OFF;
            r_cnt      <= '0;
            r_tmr      <= '0;
            r_sat      <= 1'b0;
            r_recent   <= 1'b0;
            r_idle     <= 1'b0;
            r_idle_irq <= 1'b0;
            r_wake_irq <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tmr      <= w_tmr_nxt;
            r_sat      <= w_sat_nxt;
            r_recent   <= i_en && (w_tmr_nxt != '0);
            r_idle     <= (w_state_nxt == CH_IDLE);
            r_idle_irq <= w_idle_irq;
            r_wake_irq <= w_wake_irq;
        end
    end

    assign o_count    = r_cnt;
    assign o_recent   = r_recent;
    assign o_idle     = r_idle;
    assign o_idle_irq = r_idle_irq;
    assign o_wake_irq = r_wake_irq;
    assign o_sat      = r_sat;

endmodule

// File: rtl/idle_monitor.sv
// Per-peripheral idle monitor: N independent channels fanned out from the bus.
module idle_monitor
    import idle_monitor_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 16,
    parameter int unsigned WIN_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    idle_monitor_if.slave bus
);

    if (N < N_MIN || N > N_MAX) begin : g_bad_n
        $error("idle_monitor: N out of range");
    end
    if (W < W_MIN || W > W_MAX) begin : g_bad_w
        $error("idle_monitor: W out of range");
    end
    if (WIN_W < WIN_W_MIN || WIN_W > WIN_W_MAX) begin : g_bad_win_w
        $error("idle_monitor: WIN_W out of range");
    end

    for (genvar g = 0; g < N; g++) begin : g_ch
        idle_monitor_ch #(
            .W     (W),
            .WIN_W (WIN_W)
        ) u_ch (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_en       (bus.periph_en[g]),
            .i_pulse    (bus.activity_pulse[g]),
            .i_thresh   (bus.idle_thresh),
            .i_win_len  (bus.win_len),
            .i_sat_clr  (bus.sat_clr[g]),
            .o_count    (bus.idle_count[g*W +: W]),
            .o_recent   (bus.recent_activity[g]),
            .o_idle     (bus.idle[g]),
            .o_idle_irq (bus.idle_irq[g]),
            .o_wake_irq (bus.wake_irq[g]),
            .o_sat      (bus.sat[g])
        );
    end

endmodule
